// File: rtl/bdm_sync_responder.sv
// Target side of the BDM SYNC handshake: qualifies a long host low pulse on BKGD,
// then answers with a timed low drive, an optional speedup high drive and a release.
module bdm_sync_responder #(
    parameter int MIN_SYNC_LOW   = 128,
    parameter int SETTLE_DELAY   = 16,
    parameter int RESP_LOW       = 128,
    parameter int SPEEDUP_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        bkgd_in_i,
    output logic        bkgd_out_o,
    output logic        bkgd_oe_o,
    output logic        busy_o,
    output logic        sync_detected_o,
    output logic        response_done_o,
    output logic [15:0] low_count_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_SETTLE,
        ST_DRIVE,
        ST_SPEEDUP,
        ST_RELEASE
    } state_t;

    localparam logic [15:0] MIN_C     = 16'(MIN_SYNC_LOW);
    localparam logic [15:0] SETTLE_M1 = 16'(SETTLE_DELAY - 1);
    localparam logic [15:0] RESP_M1   = 16'(RESP_LOW - 1);
    localparam logic [15:0] SPEED_M1  = 16'((SPEEDUP_CYCLES > 0) ? SPEEDUP_CYCLES - 1 : 0);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    state_t      state_q;
    logic        bkgd_meta_q;
    logic        bkgd_s_q;
    logic [15:0] cnt_q;
    logic [15:0] low_count_q;
    logic        oe_q;
    logic        out_q;
    logic        busy_q;
    logic        sync_det_q;
    logic        done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bkgd_meta_q <= 1'b1;
            bkgd_s_q    <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            low_count_q <= '0;
            oe_q        <= 1'b0;
            out_q       <= 1'b1;
            busy_q      <= 1'b0;
            sync_det_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            bkgd_meta_q <= bkgd_in_i;
            bkgd_s_q    <= bkgd_meta_q;
            sync_det_q  <= 1'b0;
            done_q      <= 1'b0;

            if (!enable_i) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                oe_q    <= 1'b0;
                out_q   <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (!bkgd_s_q) begin
                            state_q <= ST_MEASURE;
                            cnt_q   <= 16'd1;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_MEASURE: begin
                        if (!bkgd_s_q) begin
                            if (cnt_q != CNT_MAX) begin
                                cnt_q <= cnt_q + 16'd1;
                            end
                        end else if (cnt_q >= MIN_C) begin
                            low_count_q <= cnt_q;
                            sync_det_q  <= 1'b1;
                            cnt_q       <= SETTLE_M1;
                            state_q     <= ST_SETTLE;
                        end else begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end
                    end
                    ST_SETTLE: begin
                        // A new low here is the host restarting SYNC; it outranks the timeout.
                        if (!bkgd_s_q) begin
                            state_q <= ST_MEASURE;
                            cnt_q   <= 16'd1;
                        end else if (cnt_q == '0) begin
                            state_q <= ST_DRIVE;
                            cnt_q   <= RESP_M1;
                            oe_q    <= 1'b1;
                            out_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    ST_DRIVE: begin
                        if (cnt_q == '0) begin
                            out_q <= 1'b1;
                            if (SPEEDUP_CYCLES > 0) begin
                                state_q <= ST_SPEEDUP;
                                cnt_q   <= SPEED_M1;
                            end else begin
                                state_q <= ST_RELEASE;
                                oe_q    <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    ST_SPEEDUP: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_RELEASE;
                            oe_q    <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    ST_RELEASE: begin
                        // Our own low drive is still draining out of the synchronizer here.
                        if (bkgd_s_q) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        oe_q    <= 1'b0;
                        out_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bkgd_out_o      = out_q;
    assign bkgd_oe_o       = oe_q;
    assign busy_o          = busy_q;
    assign sync_detected_o = sync_det_q;
    assign response_done_o = done_q;
    assign low_count_o     = low_count_q;

endmodule

// File: tb/tb_bdm_sync_responder.sv
// Bench for bdm_sync_responder: one instance with a speedup clock, one without,
// both driven by the same host pulses and checked against per-transaction expectations.
module tb_bdm_sync_responder;

    localparam int MINL   = 128;
    localparam int SETTLE = 16;
    localparam int RESP   = 128;
    localparam int WAITC  = SETTLE + RESP + 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic host_low = 1'b0;
    always #5 clk = ~clk;

    logic        oe_a, out_a, busy_a, sync_a, done_a, pin_a;
    logic        oe_b, out_b, busy_b, sync_b, done_b, pin_b;
    logic [15:0] lc_a, lc_b;

    // Open-drain line: host pulls low, otherwise the responder's drive or the pull-up wins.
    assign pin_a = host_low ? 1'b0 : (oe_a ? out_a : 1'b1);
    assign pin_b = host_low ? 1'b0 : (oe_b ? out_b : 1'b1);

    bdm_sync_responder #(.MIN_SYNC_LOW(MINL), .SETTLE_DELAY(SETTLE), .RESP_LOW(RESP), .SPEEDUP_CYCLES(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .bkgd_in_i(pin_a),
        .bkgd_out_o(out_a), .bkgd_oe_o(oe_a), .busy_o(busy_a),
        .sync_detected_o(sync_a), .response_done_o(done_a), .low_count_o(lc_a));

    bdm_sync_responder #(.MIN_SYNC_LOW(MINL), .SETTLE_DELAY(SETTLE), .RESP_LOW(RESP), .SPEEDUP_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .bkgd_in_i(pin_b),
        .bkgd_out_o(out_b), .bkgd_oe_o(oe_b), .busy_o(busy_b),
        .sync_detected_o(sync_b), .response_done_o(done_b), .low_count_o(lc_b));

    logic m_oe[2], m_out[2], m_busy[2], m_sync[2], m_done[2];
    assign m_oe[0] = oe_a;     assign m_oe[1] = oe_b;
    assign m_out[0] = out_a;   assign m_out[1] = out_b;
    assign m_busy[0] = busy_a; assign m_busy[1] = busy_b;
    assign m_sync[0] = sync_a; assign m_sync[1] = sync_b;
    assign m_done[0] = done_a; assign m_done[1] = done_b;

    int   cyc = 0;
    int   sync_n[2], done_n[2], lo_n[2], hi_n[2], idle_drv[2], sync_at[2], oe_dly[2];
    logic oe_prev[2];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (m_sync[i]) begin
                sync_n[i]  <= sync_n[i] + 1;
                sync_at[i] <= cyc;
            end
            if (m_done[i]) done_n[i] <= done_n[i] + 1;
            if (m_oe[i] && !m_out[i]) lo_n[i] <= lo_n[i] + 1;
            if (m_oe[i] && m_out[i]) hi_n[i] <= hi_n[i] + 1;
            if (m_oe[i] && !oe_prev[i]) oe_dly[i] <= cyc - sync_at[i];
            if (m_oe[i] && !m_busy[i]) idle_drv[i] <= idle_drv[i] + 1;
            oe_prev[i] <= m_oe[i];
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int model_lc = 0;
    int s_sync[2], s_done[2], s_lo[2], s_hi[2], s_idle[2];

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int i = 0; i < 2; i++) begin
            s_sync[i] = sync_n[i];
            s_done[i] = done_n[i];
            s_lo[i]   = lo_n[i];
            s_hi[i]   = hi_n[i];
            s_idle[i] = idle_drv[i];
        end
    endtask

    function automatic int sat16(input int l);
        return (l > 65535) ? 65535 : l;
    endfunction

    // e_hi is the speedup-clock count for the instance that has one; the other never drives high.
    task automatic expect_stats(input string tag, input int e_sync, input int e_done, input int e_lo,
                                input int e_hi, input int e_lc, input bit chk_dly);
        for (int i = 0; i < 2; i++) begin
            string p = $sformatf("%s.%s", tag, (i == 0) ? "a" : "b");
            chk({p, ".sync"}, sync_n[i] - s_sync[i], e_sync);
            chk({p, ".done"}, done_n[i] - s_done[i], e_done);
            chk({p, ".lowdrv"}, lo_n[i] - s_lo[i], e_lo);
            chk({p, ".hidrv"}, hi_n[i] - s_hi[i], (i == 0) ? e_hi : 0);
            chk({p, ".idledrv"}, idle_drv[i] - s_idle[i], 0);
            chk({p, ".lowcount"}, (i == 0) ? int'(lc_a) : int'(lc_b), e_lc);
            chk({p, ".busy_end"}, (i == 0) ? int'(busy_a) : int'(busy_b), 0);
            chk({p, ".oe_end"}, (i == 0) ? int'(oe_a) : int'(oe_b), 0);
            if (chk_dly) chk({p, ".oe_delay"}, oe_dly[i], SETTLE);
        end
    endtask

    task automatic pulse(input int len);
        host_low = 1'b1;
        step(len);
        host_low = 1'b0;
    endtask

    task automatic txn(input string tag, input int len);
        bit q;
        snap();
        pulse(len);
        step(WAITC);
        q = (len >= MINL);
        if (q) model_lc = sat16(len);
        expect_stats(tag, int'(q), int'(q), q ? RESP : 0, int'(q), model_lc, q);
        $display("txn %s len=%0d qualifies=%0d low_count=%0d syncs=%0d", tag, len, q, lc_a, sync_n[0] - s_sync[0]);
    endtask

    initial begin
        int k;
        step(3);
        chk("rst.oe", int'(oe_a), 0);
        chk("rst.out", int'(out_a), 1);
        chk("rst.busy", int'(busy_a), 0);
        chk("rst.sync", int'(sync_a), 0);
        chk("rst.done", int'(done_a), 0);
        chk("rst.lowcount", int'(lc_a), 0);
        $display("txn reset oe=%0d out=%0d busy=%0d lc=%0d", oe_a, out_a, busy_a, lc_a);
        rst_n = 1'b1;
        enable = 1'b1;
        step(3);

        txn("t1", 200);
        txn("t2", 100);
        txn("edge127", 127);
        txn("edge128", 128);

        // Host restarts SYNC while the responder is settling.
        snap();
        pulse(150);
        step(5);
        pulse(300);
        step(WAITC);
        model_lc = 300;
        expect_stats("t3", 2, 1, RESP, 1, model_lc, 1'b1);
        $display("txn t3 restart low_count=%0d syncs=%0d", lc_a, sync_n[0] - s_sync[0]);

        // Enable dropped 50 clocks into the response drive.
        snap();
        pulse(200);
        model_lc = 200;
        k = 0;
        while (!oe_a && k < 100) begin
            step(1);
            k++;
        end
        chk("t4.oe_seen", int'(oe_a), 1);
        step(49);
        enable = 1'b0;
        step(1);
        chk("t4.oe_off", int'(oe_a), 0);
        chk("t4.busy_off", int'(busy_a), 0);
        step(WAITC);
        expect_stats("t4", 1, 0, 50, 0, model_lc, 1'b0);
        $display("txn t4 abort lowdrv=%0d done=%0d", lo_n[0] - s_lo[0], done_n[0] - s_done[0]);
        enable = 1'b1;
        step(2);
        txn("t4b", 130);

        // Asynchronous reset mid-SETTLE, then mid-DRIVE.
        pulse(200);
        step(8);
        #2 rst_n = 1'b0;
        #1;
        chk("t5.busy", int'(busy_a), 0);
        chk("t5.oe", int'(oe_a), 0);
        chk("t5.lowcount", int'(lc_a), 0);
        model_lc = 0;
        rst_n = 1'b1;
        step(2);
        pulse(200);
        step(60);
        chk("t5d.oe_on", int'(oe_a), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5d.oe", int'(oe_a), 0);
        chk("t5d.out", int'(out_a), 1);
        chk("t5d.busy_b", int'(busy_b), 0);
        rst_n = 1'b1;
        step(2);
        $display("txn t5 reset mid-operation oe=%0d busy=%0d lc=%0d", oe_a, busy_a, lc_a);
        txn("t5c", 128);

        for (int r = 0; r < 8; r++) begin
            txn($sformatf("rnd%0d", r), int'($urandom_range(60, 260)));
            step(int'($urandom_range(1, 10)));
        end

        txn("t6", 70000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
